// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI byte sequencer (spi_xfer_ctrl) and
// its SCLK generator (spi_clk_gen).
//   spi_state_e    : sequencer FSM state encoding
//   SPI_BYTE_W     : bits per transfer
//   SPI_HALF_EDGES : SCLK toggles per byte (two per bit)
//   bit_idx()      : maps a running bit count onto a byte bit position
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_BYTE_W     = 8;
    localparam int SPI_HALF_EDGES = 16;
    localparam int SPI_BIT_W      = $clog2(SPI_BYTE_W);
    localparam int SPI_EDGE_W     = $clog2(SPI_HALF_EDGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_CS_GAP = 2'd3
    } spi_state_e;

    // Bit n of the serial stream lives at position n (LSB-first) or
    // SPI_BYTE_W-1-n (MSB-first) of the parallel byte.
    function automatic logic [SPI_BIT_W-1:0] bit_idx(input logic [SPI_BIT_W-1:0] n,
                                                     input logic                 lsb);
        logic [SPI_BIT_W-1:0] top;
        top = SPI_BIT_W'(SPI_BYTE_W - 1);
        return lsb ? n : (top - n);
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// SCLK divider for the SPI sequencer. While en is high it counts half-periods
// of clk_div+1 clk cycles. The first half-period after en rises is a setup
// interval with no SCLK toggle; every later half-period ends with a toggle.
// While en is low SCLK is parked at cpol and the divider is cleared.
//   clk, rst_n  : system clock, async active-low reset
//   en          : run the divider
//   clk_div     : half-period length minus one
//   cpol        : SCLK idle level
//   sclk        : registered SCLK
//   half_stb    : last clk cycle of any half-period (including setup)
//   lead_stb    : SCLK leaves cpol at the coming clk edge
//   trail_stb   : SCLK returns to cpol at the coming clk edge
// The strobes are combinational so the sequencer acts on the same clk edge
// that moves SCLK.
// ---------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cpol,
    output logic             sclk,
    output logic             half_stb,
    output logic             lead_stb,
    output logic             trail_stb
);

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic             sclk_q;
    logic             armed_q;   // setup half-period has elapsed

    assign half_stb  = en && (cnt_q == clk_div);
    assign lead_stb  = half_stb && armed_q && (sclk_q == cpol);
    assign trail_stb = half_stb && armed_q && (sclk_q != cpol);
    assign sclk      = sclk_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
            armed_q <= 1'b0;
        end else if (!en) begin
            cnt_q   <= '0;
            sclk_q  <= cpol;
            armed_q <= 1'b0;
        end else if (half_stb) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
            if (armed_q) begin
                sclk_q <= ~sclk_q;
            end
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl
// Byte-level SPI master sequencer. Accepts one byte per start pulse in IDLE,
// owns chip select, generates SCLK in all four CPOL/CPHA modes, shifts MOSI
// out and MISO in, and pulses done for one cycle with rx_data valid.
//   clk, rst_n        : system clock, async active-low reset
//   start             : request a byte transfer (honoured only in IDLE)
//   tx_data           : byte to send
//   clk_div           : SCLK half-period = clk_div+1 clk cycles
//   cpol, cpha        : SPI mode
//   last              : release cs_n after this byte
//   lsb_first         : bit order (only with SPI_LSB_FIRST_EN)
//   miso              : serial data from slave
//   busy              : transfer in progress
//   done, rx_data     : completion pulse and received byte
//   sclk, mosi, cs_n  : SPI pins, all registered
// All transfer controls are captured at accept.
// Build option: define SPI_LSB_FIRST_EN to honour lsb_first; otherwise the
// port is ignored and every transfer is MSB-first.
// ---------------------------------------------------------------------------
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int CS_IDLE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  last,
    input  logic                  lsb_first,
    input  logic                  miso,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n
);

    localparam int GAP_W = (CS_IDLE_CYC > 1) ? $clog2(CS_IDLE_CYC) : 1;

    localparam logic [SPI_BIT_W-1:0]  BIT_LAST  = SPI_BIT_W'(SPI_BYTE_W - 1);
    localparam logic [SPI_BIT_W-1:0]  BIT_ONE   = SPI_BIT_W'(1);
    localparam logic [SPI_EDGE_W-1:0] EDGE_ONE  = SPI_EDGE_W'(1);
    localparam logic [SPI_EDGE_W-1:0] EDGE_END  = SPI_EDGE_W'(SPI_HALF_EDGES);
    localparam logic [SPI_EDGE_W-1:0] EDGE_FIN  = SPI_EDGE_W'(SPI_HALF_EDGES - 1);
    localparam logic [GAP_W-1:0]      GAP_LOAD  = GAP_W'(CS_IDLE_CYC - 1);
    localparam logic [GAP_W-1:0]      GAP_ONE   = GAP_W'(1);

    spi_state_e            state_q;
    logic [SPI_BYTE_W-1:0] tx_q;
    logic [SPI_BYTE_W-1:0] rx_sr_q;
    logic [SPI_BYTE_W-1:0] rx_sr_d;
    logic [SPI_BIT_W-1:0]  bit_q;
    logic [SPI_EDGE_W-1:0] edge_q;
    logic [GAP_W-1:0]      gap_q;
    logic [DIV_W-1:0]      clk_div_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  last_q;
    logic                  lsb_q;
    logic                  busy_q;
    logic                  done_q;
    logic [SPI_BYTE_W-1:0] rx_data_q;
    logic                  mosi_q;
    logic                  cs_n_q;

    logic lsb_in;
    logic accept;
    logic cpol_src;
    logic gen_en;
    logic half_stb;
    logic lead_stb;
    logic trail_stb;
    logic sample_stb;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    logic unused_lsb_first;
    assign unused_lsb_first = lsb_first;
    assign lsb_in           = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && start;

    // Feed the new cpol straight through on accept so SCLK already sits at
    // the new idle level in the first SETUP cycle.
    assign cpol_src = accept ? cpol : cpol_q;

    // The divider stops once the 16th toggle has been issued; the sequencer
    // spends that one cycle in SHIFT presenting done.
    assign gen_en = (state_q == ST_SETUP) ||
                    ((state_q == ST_SHIFT) && (edge_q != EDGE_END));

    assign sample_stb = cpha_q ? trail_stb : lead_stb;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (gen_en),
        .clk_div   (clk_div_q),
        .cpol      (cpol_src),
        .sclk      (sclk),
        .half_stb  (half_stb),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        rx_sr_d = rx_sr_q;
        if (sample_stb) begin
            rx_sr_d[bit_idx(bit_q, lsb_q)] = miso;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            bit_q     <= '0;
            edge_q    <= '0;
            gap_q     <= '0;
            clk_div_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            last_q    <= 1'b0;
            lsb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            done_q  <= 1'b0;
            rx_sr_q <= rx_sr_d;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tx_q      <= tx_data;
                        clk_div_q <= clk_div;
                        cpol_q    <= cpol;
                        cpha_q    <= cpha;
                        last_q    <= last;
                        lsb_q     <= lsb_in;
                        bit_q     <= '0;
                        edge_q    <= '0;
                        mosi_q    <= tx_data[bit_idx('0, lsb_in)];
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (half_stb) begin
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (edge_q == EDGE_END) begin
                        // Cycle in which done is presented.
                        if (last_q) begin
                            cs_n_q  <= 1'b1;
                            gap_q   <= GAP_LOAD;
                            state_q <= ST_CS_GAP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else if (lead_stb || trail_stb) begin
                        edge_q <= edge_q + EDGE_ONE;

                        // Bit counter advances on the first seven trailing
                        // edges and then holds at the final bit.
                        if (trail_stb && (bit_q != BIT_LAST)) begin
                            bit_q <= bit_q + BIT_ONE;
                            if (!cpha_q) begin
                                mosi_q <= tx_q[bit_idx(bit_q + BIT_ONE, lsb_q)];
                            end
                        end
                        if (cpha_q && lead_stb) begin
                            mosi_q <= tx_q[bit_idx(bit_q, lsb_q)];
                        end

                        if (edge_q == EDGE_FIN) begin
                            done_q    <= 1'b1;
                            rx_data_q <= rx_sr_d;
                        end
                    end
                end

                ST_CS_GAP: begin
                    if (gap_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_ONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_ctrl
// Directed self-checking bench for spi_xfer_ctrl. Cycle numbering follows the
// block's timing description: the accept cycle is 0, outputs are observed 1
// time unit after each rising clk edge.
// ---------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

    localparam int BOUND = 5000;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] clk_div;
    logic       cpol;
    logic       cpha;
    logic       last;
    logic       lsb_first;
    logic       miso;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       cs_n;

    logic       loop_en;
    logic       miso_val;

    int total;
    int bad;
    int cyc;
    int rise_cnt;
    int done_cnt;
    int base;
    logic [7:0] mosi_log;

    assign miso = loop_en ? mosi : miso_val;

    spi_xfer_ctrl #(
        .DIV_W       (8),
        .CS_IDLE_CYC (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tx_data   (tx_data),
        .clk_div   (clk_div),
        .cpol      (cpol),
        .cpha      (cpha),
        .last      (last),
        .lsb_first (lsb_first),
        .miso      (miso),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge sclk) begin
        rise_cnt <= rise_cnt + 1;
        mosi_log <= {mosi_log[6:0], mosi};
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_xfer(input logic [7:0] d, input logic [7:0] div,
                              input logic pol, input logic pha,
                              input logic lst, input logic lsb);
        tx_data   = d;
        clk_div   = div;
        cpol      = pol;
        cpha      = pha;
        last      = lst;
        lsb_first = lsb;
        start     = 1'b1;
        cyc       = 0;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < BOUND) begin
            tick();
            n++;
        end
        check({tag, " done seen"}, done, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < BOUND) begin
            tick();
            n++;
        end
        check({tag, " busy released"}, busy, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        rise_cnt  = 0;
        done_cnt  = 0;
        mosi_log  = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        tx_data   = '0;
        clk_div   = '0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        last      = 1'b0;
        lsb_first = 1'b0;
        loop_en   = 1'b0;
        miso_val  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst busy",    busy,    1'b0);
        check("rst done",    done,    1'b0);
        check("rst rx_data", rx_data, 8'h00);
        check("rst sclk",    sclk,    1'b0);
        check("rst mosi",    mosi,    1'b0);
        check("rst cs_n",    cs_n,    1'b1);
        rst_n = 1'b1;
        tick();

        // Mode 0, clk_div=1, A5 looped back, last=1
        loop_en = 1'b1;
        base    = rise_cnt;
        start_xfer(8'hA5, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("m0 c1 busy", busy, 1'b1);
        check("m0 c1 cs_n", cs_n, 1'b0);
        check("m0 c1 sclk", sclk, 1'b0);
        check("m0 c1 mosi", mosi, 1'b1);
        wait_done("m0");
        check("m0 done cycle", cyc, 35);
        check("m0 rx_data", rx_data, 8'hA5);
        check("m0 sclk rises", rise_cnt - base, 8);
        check("m0 sclk end", sclk, 1'b0);
        tick();
        check("m0 done width", done, 1'b0);
        check("m0 gap cs_n", cs_n, 1'b1);
        check("m0 gap busy", busy, 1'b1);
        tick();
        check("m0 gap2 busy", busy, 1'b1);
        tick();
        check("m0 idle busy", busy, 1'b0);
        check("m0 idle cs_n", cs_n, 1'b1);
        check("m0 rx hold", rx_data, 8'hA5);

        // Mode 3, clk_div=0, 3C, miso tied high
        loop_en  = 1'b0;
        miso_val = 1'b1;
        start_xfer(8'h3C, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("m3 c1 sclk", sclk, 1'b1);
        check("m3 c1 cs_n", cs_n, 1'b0);
        wait_done("m3");
        check("m3 done cycle", cyc, 18);
        check("m3 rx_data", rx_data, 8'hFF);
        check("m3 mosi seq", mosi_log, 8'h3C);
        check("m3 sclk end", sclk, 1'b1);
        wait_idle("m3");
        check("m3 idle sclk", sclk, 1'b1);

        // Two-byte frame: 12 (last=0) then 34 (last=1)
        loop_en = 1'b1;
        base    = done_cnt;
        start_xfer(8'h12, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done("frame b0");
        check("frame b0 rx", rx_data, 8'h12);
        check("frame b0 cs_n", cs_n, 1'b0);
        tick();
        check("frame gap busy", busy, 1'b0);
        check("frame gap cs_n", cs_n, 1'b0);
        check("frame gap sclk", sclk, 1'b0);
        start_xfer(8'h34, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("frame b1 cs_n", cs_n, 1'b0);
        wait_done("frame b1");
        check("frame b1 rx", rx_data, 8'h34);
        check("frame b1 cs_n at done", cs_n, 1'b0);
        tick();
        check("frame cs_n release", cs_n, 1'b1);
        wait_idle("frame");
        check("frame done count", done_cnt - base, 2);

        // start pulsed mid-SHIFT is ignored
        base = done_cnt;
        start_xfer(8'hC3, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) tick();
        tx_data = 8'hFF;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done("ign");
        check("ign done cycle", cyc, 35);
        check("ign rx_data", rx_data, 8'hC3);
        wait_idle("ign");
        repeat (40) tick();
        check("ign done count", done_cnt - base, 1);
        check("ign stays idle", busy, 1'b0);

        // Bit order
        start_xfer(8'h01, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef SPI_LSB_FIRST_EN
        check("lsb first mosi", mosi, 1'b1);
`else
        check("lsb first mosi", mosi, 1'b0);
`endif
        wait_done("lsb");
        check("lsb rx_data", rx_data, 8'h01);
        wait_idle("lsb");

        // Reset during bit 4 of SHIFT, then recover with 5A
        base = done_cnt;
        start_xfer(8'h96, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        while (cyc < 20) tick();
        check("rst pre busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid rst cs_n", cs_n, 1'b1);
        check("mid rst sclk", sclk, 1'b0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst mosi", mosi, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        check("mid rst no done", done_cnt - base, 0);
        check("mid rst rx cleared", rx_data, 8'h00);
        start_xfer(8'h5A, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_done("post rst");
        check("post rst rx", rx_data, 8'h5A);
        wait_idle("post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
